lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 119 +++++++++++
 tb/tb_lsu_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store sequencer for a single-port word memory with a one-cycle read latency.
// Define LSU_MISALIGN_TRAP_EN to report misaligned LH/LHU/SH/LW/SW as errors instead of aligning them down.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
    state_t      state;
    logic        op_we;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic [15:0] op_wdata;
    logic        misalign;
    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready = state == IDLE;

    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        req_err = req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]) || misalign;
    end

    // Misaligned offsets fall through naturally: halfwords only look at addr[1], words ignore addr[1:0].
    always_comb begin
        rd_byte   = 8'(mem_rdata >> {op_off, 3'b000});
        rd_half   = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = op_f3 == 3'b000 ? {{24{rd_byte[7]}}, rd_byte} :
                    op_f3 == 3'b001 ? {{16{rd_half[15]}}, rd_half} :
                    op_f3 == 3'b100 ? {24'b0, rd_byte} :
                    op_f3 == 3'b101 ? {16'b0, rd_half} : mem_rdata;
        merged    = op_f3[0] ? (op_off[1] ? {op_wdata, mem_rdata[15:0]} : {mem_rdata[31:16], op_wdata}) :
                    (mem_rdata & ~(32'hFF << {op_off, 3'b000})) | ({24'b0, op_wdata[7:0]} << {op_off, 3'b000});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_we      <= 1'b0;
            op_f3      <= 3'b000;
            op_off     <= 2'b00;
            op_wdata   <= 16'h0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op_we    <= req_we;
                    op_f3    <= req_funct3;
                    op_off   <= req_addr[1:0];
                    op_wdata <= req_wdata[15:0];
                    if (req_err) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        state     <= req_we && req_funct3 == 3'b010 ? WRITE : READ;
                        mem_en    <= 1'b1;
                        mem_we    <= req_we && req_funct3 == 3'b010;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_wdata <= req_wdata;
                    end
                end
                READ: begin
                    state  <= WAIT;
                    mem_en <= 1'b0;
                end
                WAIT: if (op_we) begin
                    state     <= WRITE;
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_wdata <= merged;
                end else begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                end
                WRITE: begin
                    state      <= RESP;
                    mem_en     <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized load/store traffic against a word-array reference of the memory image.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic [31:0] last_addr;
    int n_vec = 0, n_bad = 0, en_cnt = 0, wr_cnt = 0, resp_cnt = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt    <= en_cnt + 1;
            last_addr <= mem_addr;
            if (mem_we) begin
                mem[mem_addr[5:2]] <= mem_wdata;
                wr_cnt <= wr_cnt + 1;
            end else
                mem_rdata <= mem[mem_addr[5:2]];
        end
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outcome of one request, straight from the RV32I load/store rules; updates ref_mem.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd, output int n_en, output int n_wr);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = ref_mem[a[5:2]];
        b = w[8*a[1:0] +: 8];
        h = w[16*a[1] +: 16];
        err = f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        err = err || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
`endif
        rd = 32'h0; lat = 1; n_en = 0; n_wr = 0;
        if (!err && we) begin
            if (f3 == 3'd0) w[8*a[1:0] +: 8] = wd[7:0];
            else if (f3 == 3'd1) w[16*a[1] +: 16] = wd[15:0];
            else w = wd;
            ref_mem[a[5:2]] = w;
            lat  = f3 == 3'd2 ? 2 : 4;
            n_en = f3 == 3'd2 ? 1 : 2;
            n_wr = 1;
        end else if (!err) begin
            lat  = 3;
            n_en = 1;
            rd   = f3 == 3'd0 ? {{24{b[7]}}, b} : f3 == 3'd1 ? {{16{h[15]}}, h} :
                   f3 == 3'd4 ? {24'h0, b} : f3 == 3'd5 ? {16'h0, h} : w;
        end
    endtask

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int lat, n_en, n_wr, en0, wr0, k;
        logic err;
        logic [31:0] rd;
        model(we, f3, a, wd, lat, err, rd, n_en, n_wr);
        @(negedge clk);
        chk("ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        en0 = en_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        k = 1;
        while (!resp_valid && k < 12) begin
            req_valid = 1'($urandom);
            @(posedge clk); #1;
            k++;
        end
        req_valid = 1'b0;
        chk("latency", k, lat);
        chk("resp_err", resp_err, err);
        chk("resp_rdata", resp_rdata, rd);
        @(posedge clk); #1;
        chk("pulse", resp_valid, 0);
        chk("ready_after", req_ready, 1);
        chk("rdata_hold", resp_rdata, rd);
        chk("mem_en_cnt", en_cnt - en0, n_en);
        chk("mem_wr_cnt", wr_cnt - wr0, n_wr);
        if (n_en > 0) chk("mem_addr", last_addr, {a[31:2], 2'b00});
        chk("mem_word", mem[a[5:2]], ref_mem[a[5:2]]);
    endtask

    initial begin
        int wr0, r0;
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("rst_ready", req_ready, 1);

        do_op(1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("sw_word", mem[4], 32'hDEADBEEF);
        for (int i = 0; i < 16; i++) do_op(1, 3'b010, 32'(i * 4), $urandom);
        do_op(1, 3'b010, 32'h10, 32'h112283FF);
        do_op(0, 3'b000, 32'h11, 0);
        chk("lb_x11", resp_rdata, 32'hFFFFFF83);
        do_op(0, 3'b100, 32'h11, 0);
        chk("lbu_x11", resp_rdata, 32'h00000083);
        do_op(0, 3'b001, 32'h12, 0);
        chk("lh_x12", resp_rdata, 32'h00001122);
        do_op(1, 3'b010, 32'h20, 32'hAABBCCDD);
        do_op(1, 3'b000, 32'h22, 32'h55);
        chk("sb_word", mem[8], 32'hAA55CCDD);
        do_op(0, 3'b010, 32'h06, 0);
        do_op(0, 3'b011, 32'h10, 0);

        // Reset in the WAIT cycle of an SH: nothing may be written or answered.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h1234;
        wr0 = wr_cnt; r0 = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("arst_mem_en", mem_en, 0);
        chk("arst_mem_we", mem_we, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_resp_err", resp_err, 0);
        chk("arst_resp_rdata", resp_rdata, 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_no_write", wr_cnt - wr0, 0);
        chk("arst_no_resp", resp_cnt - r0, 0);
        chk("arst_word", mem[8], ref_mem[8]);
        do_op(0, 3'b010, 32'h20, 0);

        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            do_op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
